// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the ID-stage decoder and the ID/EX control pipeline.
package pipe_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {
        ALU_R      = 3'd0,
        ALU_I      = 3'd1,
        ALU_B      = 3'd2,
        ALU_ADDR   = 3'd3,
        ALU_MULDIV = 3'd4,
        ALU_LUI    = 3'd5,
        ALU_AUIPC  = 3'd6,
        ALU_JAL    = 3'd7
    } alu_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_MULDIV = 1'b1
    } state_e;

    typedef struct packed {
        logic    jalr;
        logic    jal;
        logic    branch;
        logic    mem_to_reg;
        logic    mem_write;
        logic    mem_read;
        logic    alu_src;
        logic    reg_write;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = ctrl_t'(11'b0);

endpackage

// File: rtl/control_dec.sv
// Combinational opcode decoder: instruction word to control bundle and operand usage.
module control_dec
    import pipe_ctrl_pkg::*;
#(
    parameter int M_EXT = 1
) (
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl,
    output logic        o_rs1_used,
    output logic        o_rs2_used,
    output logic        o_is_muldiv,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic [6:0] w_funct7;
    logic       w_unused_bits;

    assign w_opcode      = i_instr[6:0];
    assign w_funct7      = i_instr[31:25];
    assign w_unused_bits = ^i_instr[24:7];

    // Opcode table; anything not listed is flagged illegal and decodes as a bubble.
    always_comb begin
        o_ctrl      = CTRL_BUBBLE;
        o_rs1_used  = 1'b0;
        o_rs2_used  = 1'b0;
        o_is_muldiv = 1'b0;
        o_illegal   = 1'b0;
        case (w_opcode)
            OP_R: begin
                if (w_funct7 == F7_MULDIV) begin
                    if (M_EXT != 0) begin
                        o_ctrl.reg_write = 1'b1;
                        o_ctrl.alu_op    = ALU_MULDIV;
                        o_rs1_used       = 1'b1;
                        o_rs2_used       = 1'b1;
                        o_is_muldiv      = 1'b1;
                    end else begin
                        o_illegal = 1'b1;
                    end
                end else begin
                    o_ctrl.reg_write = 1'b1;
                    o_ctrl.alu_op    = ALU_R;
                    o_rs1_used       = 1'b1;
                    o_rs2_used       = 1'b1;
                end
            end
            OP_I: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALU_I;
                o_rs1_used       = 1'b1;
            end
            OP_LOAD: begin
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.alu_op     = ALU_ADDR;
                o_rs1_used        = 1'b1;
            end
            OP_STORE: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_op    = ALU_ADDR;
                o_rs1_used       = 1'b1;
                o_rs2_used       = 1'b1;
            end
            OP_JALR: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.jalr      = 1'b1;
                o_ctrl.alu_op    = ALU_ADDR;
                o_rs1_used       = 1'b1;
            end
            OP_BRANCH: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.alu_op = ALU_B;
                o_rs1_used    = 1'b1;
                o_rs2_used    = 1'b1;
            end
            OP_JAL: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.jal       = 1'b1;
                o_ctrl.alu_op    = ALU_JAL;
            end
            OP_LUI: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALU_LUI;
            end
            OP_AUIPC: begin
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.alu_op    = ALU_AUIPC;
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipe_control.sv
// ID/EX control stage: decode, load-use bubble, MUL/DIV hold and redirect squash.
//   state     | meaning
//   ST_IDLE   | EX advances every cycle unless a load-use bubble is inserted
//   ST_MULDIV | MUL/DIV occupies EX; EX and IF/ID hold while the counter runs down
module pipe_control
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int MULDIV_LAT = 4,
    parameter int M_EXT      = 1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              Valid_i,
    input  logic [31:0]       Instr_i,
    input  logic              Flush_i,
    output logic              Ready_o,
    output logic              ExValid_o,
    output logic              Jalr_o,
    output logic              Jal_o,
    output logic              Branch_o,
    output logic              MemtoReg_o,
    output logic              MemWrite_o,
    output logic              MemRead_o,
    output logic              ALUSrc_o,
    output logic              RegWrite_o,
    output logic [2:0]        ALUOp_o,
    output logic [REG_AW-1:0] Rd_o,
    output logic              Busy_o,
    output logic              Illegal_o
);

    localparam int               CNT_W    = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 1);

    ctrl_t             w_dec_ctrl;
    logic              w_rs1_used;
    logic              w_rs2_used;
    logic              w_is_muldiv;
    logic              w_illegal;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic              w_load_use;

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    ctrl_t             r_ctrl;
    logic [REG_AW-1:0] r_rd;
    logic              r_ex_valid;
    logic              r_illegal;

    control_dec #(.M_EXT(M_EXT)) u_dec (
        .i_instr     (Instr_i),
        .o_ctrl      (w_dec_ctrl),
        .o_rs1_used  (w_rs1_used),
        .o_rs2_used  (w_rs2_used),
        .o_is_muldiv (w_is_muldiv),
        .o_illegal   (w_illegal)
    );

    assign w_rd  = Instr_i[7 +: REG_AW];
    assign w_rs1 = Instr_i[15 +: REG_AW];
    assign w_rs2 = Instr_i[20 +: REG_AW];

    // A load into x0 never produces a dependency, so it is excluded here.
    assign w_load_use = r_ex_valid && r_ctrl.mem_read && (r_rd != '0) && Valid_i &&
                        ((w_rs1_used && (w_rs1 == r_rd)) || (w_rs2_used && (w_rs2 == r_rd)));

    assign Ready_o = Flush_i || ((r_state == ST_IDLE) && !w_load_use);

    // ID/EX register and MUL/DIV occupancy FSM, priority flush > hold > bubble > advance.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ctrl     <= CTRL_BUBBLE;
            r_rd       <= '0;
            r_ex_valid <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (Flush_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_ctrl     <= CTRL_BUBBLE;
            r_rd       <= '0;
            r_ex_valid <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (r_state == ST_MULDIV) begin
            r_illegal <= 1'b0;
            r_cnt     <= r_cnt - 1'b1;
            if (r_cnt == CNT_W'(1)) begin
                r_state <= ST_IDLE;
            end
        end else if (w_load_use) begin
            r_ctrl     <= CTRL_BUBBLE;
            r_rd       <= '0;
            r_ex_valid <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (Valid_i && !w_illegal) begin
            r_ctrl     <= w_dec_ctrl;
            r_rd       <= w_rd;
            r_ex_valid <= 1'b1;
            r_illegal  <= 1'b0;
            if (w_is_muldiv && (MULDIV_LAT > 1)) begin
                r_state <= ST_MULDIV;
                r_cnt   <= CNT_LOAD;
            end
        end else begin
            r_ctrl     <= CTRL_BUBBLE;
            r_rd       <= '0;
            r_ex_valid <= 1'b0;
            r_illegal  <= Valid_i && w_illegal;
        end
    end

    assign ExValid_o  = r_ex_valid;
    assign Jalr_o     = r_ctrl.jalr;
    assign Jal_o      = r_ctrl.jal;
    assign Branch_o   = r_ctrl.branch;
    assign MemtoReg_o = r_ctrl.mem_to_reg;
    assign MemWrite_o = r_ctrl.mem_write;
    assign MemRead_o  = r_ctrl.mem_read;
    assign ALUSrc_o   = r_ctrl.alu_src;
    assign RegWrite_o = r_ctrl.reg_write;
    assign ALUOp_o    = r_ctrl.alu_op;
    assign Rd_o       = r_rd;
    assign Busy_o     = (r_state == ST_MULDIV);
    assign Illegal_o  = r_illegal;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control with a scoreboard of expected EX-stage contents.
module tb_pipe_control;

    localparam logic [31:0] I_ADD3  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_LW5   = 32'h0000A283; // lw  x5,0(x1)
    localparam logic [31:0] I_ADD6  = 32'h00228333; // add x6,x5,x2
    localparam logic [31:0] I_LW0   = 32'h0000A003; // lw  x0,0(x1)
    localparam logic [31:0] I_ADD60 = 32'h00000333; // add x6,x0,x0
    localparam logic [31:0] I_MUL7  = 32'h022083B3; // mul x7,x1,x2
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    // {Jalr, Jal, Branch, MemtoReg, MemWrite, MemRead, ALUSrc, RegWrite}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_RW   = 8'b0000_0001;
    localparam logic [7:0] C_LD   = 8'b0001_0111;

    typedef struct {
        string      tag;
        logic       exv;
        logic [7:0] ctrl;
        logic [2:0] op;
        logic [4:0] rd;
        logic       busy;
        logic       ill;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        Valid_i = 1'b0;
    logic [31:0] Instr_i = 32'h0;
    logic        Flush_i = 1'b0;

    logic       Ready_o, ExValid_o, Jalr_o, Jal_o, Branch_o, MemtoReg_o, MemWrite_o;
    logic       MemRead_o, ALUSrc_o, RegWrite_o, Busy_o, Illegal_o;
    logic [2:0] ALUOp_o;
    logic [4:0] Rd_o;

    logic       rdy_x, exv_x, jalr_x, jal_x, br_x, m2r_x, mw_x, mr_x, as_x, rw_x, busy_x, ill_x;
    logic [2:0] op_x;
    logic [4:0] rd_x;

    logic       rdy_l, exv_l, jalr_l, jal_l, br_l, m2r_l, mw_l, mr_l, as_l, rw_l, busy_l, ill_l;
    logic [2:0] op_l;
    logic [4:0] rd_l;

    logic [7:0] w_ctrl;
    assign w_ctrl = {Jalr_o, Jal_o, Branch_o, MemtoReg_o, MemWrite_o, MemRead_o, ALUSrc_o, RegWrite_o};

    always #5 clk_i = ~clk_i;

    pipe_control #(.REG_AW(5), .MULDIV_LAT(4), .M_EXT(1)) u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .Valid_i(Valid_i), .Instr_i(Instr_i), .Flush_i(Flush_i),
        .Ready_o(Ready_o), .ExValid_o(ExValid_o), .Jalr_o(Jalr_o), .Jal_o(Jal_o),
        .Branch_o(Branch_o), .MemtoReg_o(MemtoReg_o), .MemWrite_o(MemWrite_o),
        .MemRead_o(MemRead_o), .ALUSrc_o(ALUSrc_o), .RegWrite_o(RegWrite_o),
        .ALUOp_o(ALUOp_o), .Rd_o(Rd_o), .Busy_o(Busy_o), .Illegal_o(Illegal_o)
    );

    pipe_control #(.REG_AW(5), .MULDIV_LAT(4), .M_EXT(0)) u_noext (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .Valid_i(Valid_i), .Instr_i(Instr_i), .Flush_i(Flush_i),
        .Ready_o(rdy_x), .ExValid_o(exv_x), .Jalr_o(jalr_x), .Jal_o(jal_x),
        .Branch_o(br_x), .MemtoReg_o(m2r_x), .MemWrite_o(mw_x),
        .MemRead_o(mr_x), .ALUSrc_o(as_x), .RegWrite_o(rw_x),
        .ALUOp_o(op_x), .Rd_o(rd_x), .Busy_o(busy_x), .Illegal_o(ill_x)
    );

    pipe_control #(.REG_AW(5), .MULDIV_LAT(1), .M_EXT(1)) u_lat1 (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .Valid_i(Valid_i), .Instr_i(Instr_i), .Flush_i(Flush_i),
        .Ready_o(rdy_l), .ExValid_o(exv_l), .Jalr_o(jalr_l), .Jal_o(jal_l),
        .Branch_o(br_l), .MemtoReg_o(m2r_l), .MemWrite_o(mw_l),
        .MemRead_o(mr_l), .ALUSrc_o(as_l), .RegWrite_o(rw_l),
        .ALUOp_o(op_l), .Rd_o(rd_l), .Busy_o(busy_l), .Illegal_o(ill_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".exv"},   32'(ExValid_o), 32'd0);
        chk({tag, ".ctrl"},  32'(w_ctrl),    32'd0);
        chk({tag, ".op"},    32'(ALUOp_o),   32'd0);
        chk({tag, ".rd"},    32'(Rd_o),      32'd0);
        chk({tag, ".busy"},  32'(Busy_o),    32'd0);
        chk({tag, ".ill"},   32'(Illegal_o), 32'd0);
        chk({tag, ".ready"}, 32'(Ready_o),   32'd1);
    endtask

    // Drive one ID-stage cycle, check Ready before the edge, then score the EX contents.
    task automatic step(input string tag, input logic v, input logic [31:0] ins, input logic fl,
                        input logic e_rdy, input logic e_exv, input logic [7:0] e_ctrl,
                        input logic [2:0] e_op, input logic [4:0] e_rd, input logic e_busy,
                        input logic e_ill);
        exp_t e;
        Valid_i = v;
        Instr_i = ins;
        Flush_i = fl;
        #1;
        chk({tag, ".ready"}, 32'(Ready_o), 32'(e_rdy));
        sb.push_back('{tag, e_exv, e_ctrl, e_op, e_rd, e_busy, e_ill});
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".exv"},  32'(ExValid_o), 32'(e.exv));
        chk({e.tag, ".ctrl"}, 32'(w_ctrl),    32'(e.ctrl));
        chk({e.tag, ".op"},   32'(ALUOp_o),   32'(e.op));
        chk({e.tag, ".rd"},   32'(Rd_o),      32'(e.rd));
        chk({e.tag, ".busy"}, 32'(Busy_o),    32'(e.busy));
        chk({e.tag, ".ill"},  32'(Illegal_o), 32'(e.ill));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk_reset("por");
        @(negedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        //    tag        v     instr    fl  rdy  exv ctrl    op    rd  busy ill
        step("add",     1'b1, I_ADD3,  0,  1,   1,  C_RW,   3'd0, 3,  0,   0);
        step("idle",    1'b0, 32'h0,   0,  1,   0,  C_NONE, 3'd0, 0,  0,   0);
        step("lw5",     1'b1, I_LW5,   0,  1,   1,  C_LD,   3'd3, 5,  0,   0);
        step("lu_stall",1'b1, I_ADD6,  0,  0,   0,  C_NONE, 3'd0, 0,  0,   0);
        step("lu_go",   1'b1, I_ADD6,  0,  1,   1,  C_RW,   3'd0, 6,  0,   0);
        step("lw0",     1'b1, I_LW0,   0,  1,   1,  C_LD,   3'd3, 0,  0,   0);
        step("use_x0",  1'b1, I_ADD60, 0,  1,   1,  C_RW,   3'd0, 6,  0,   0);

        step("mul",     1'b1, I_MUL7,  0,  1,   1,  C_RW,   3'd4, 7,  1,   0);
        chk("noext.ill",  32'(ill_x),  32'd1);
        chk("noext.exv",  32'(exv_x),  32'd0);
        chk("noext.rw",   32'(rw_x),   32'd0);
        chk("lat1.busy",  32'(busy_l), 32'd0);
        Valid_i = 1'b1;
        Instr_i = I_ADD3;
        #1;
        chk("lat1.ready", 32'(rdy_l),  32'd1);
        step("mul_h1",  1'b1, I_ADD3,  0,  0,   1,  C_RW,   3'd4, 7,  1,   0);
        chk("lat1.add",   32'(rd_l),   32'd3);
        step("mul_h2",  1'b1, I_ADD3,  0,  0,   1,  C_RW,   3'd4, 7,  1,   0);
        step("mul_h3",  1'b1, I_ADD3,  0,  0,   1,  C_RW,   3'd4, 7,  0,   0);
        step("mul_use", 1'b1, I_ADD3,  0,  1,   1,  C_RW,   3'd0, 3,  0,   0);

        step("mul2",    1'b1, I_MUL7,  0,  1,   1,  C_RW,   3'd4, 7,  1,   0);
        step("mul2_h1", 1'b1, I_ADD3,  0,  0,   1,  C_RW,   3'd4, 7,  1,   0);
        step("flush",   1'b1, I_ADD3,  1,  1,   0,  C_NONE, 3'd0, 0,  0,   0);
        step("post_fl", 1'b1, I_ADD3,  0,  1,   1,  C_RW,   3'd0, 3,  0,   0);

        step("lw5_b",   1'b1, I_LW5,   0,  1,   1,  C_LD,   3'd3, 5,  0,   0);
        step("fl_haz",  1'b1, I_ADD6,  1,  1,   0,  C_NONE, 3'd0, 0,  0,   0);

        step("illegal", 1'b1, I_BAD,   0,  1,   0,  C_NONE, 3'd0, 0,  0,   1);
        step("ill_off", 1'b0, 32'h0,   0,  1,   0,  C_NONE, 3'd0, 0,  0,   0);

        step("mul3",    1'b1, I_MUL7,  0,  1,   1,  C_RW,   3'd4, 7,  1,   0);
        Valid_i = 1'b1;
        Instr_i = I_ADD3;
        #2;
        rst_n_i = 1'b0;
        #1;
        chk_reset("rst_mid");
        @(negedge clk_i);
        rst_n_i = 1'b1;
        step("add_rst", 1'b1, I_ADD3,  0,  1,   1,  C_RW,   3'd0, 3,  0,   0);
        step("end",     1'b0, 32'h0,   0,  1,   0,  C_NONE, 3'd0, 0,  0,   0);

        chk("sb.empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
